// File: rtl/seq_pkg.sv
// Shared types and constants for the opcode sequencer: FSM states, program-word
// field positions and the ALU load opcodes used by program assemblers.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } seq_state_e;

  localparam int HALT_BIT = 15;
  localparam int HOLD_MSB = 14;
  localparam int HOLD_LSB = 12;
  localparam int OPC_MSB  = 11;

  localparam logic [3:0] ALU_LD_A = 4'b1001;
  localparam logic [3:0] ALU_LD_B = 4'b1011;
  localparam logic [3:0] ALU_LD_C = 4'b1100;

  // Field order follows the ROM word layout, MSB first.
  typedef struct packed {
    logic                       halt;
    logic [HOLD_MSB-HOLD_LSB:0] hold;
    logic [OPC_MSB:0]           opc;
  } prog_word_t;

  function automatic prog_word_t unpack_word(input logic [HALT_BIT:0] w);
    return prog_word_t'(w);
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Loadable 8-bit down-counter bounding how long an issued opcode waits for ack.
// expired flags the cycle whose decrement brings the count to zero.
module ack_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != 8'd0)
      count <= count - 8'd1;
  end

  assign expired = en && (count == 8'd1);

endmodule

// File: rtl/opcode_sequencer.sv
// Fetches program words from a synchronous ROM and issues 12-bit opcodes with a
// valid/ack handshake; stops on HALT, end of program, or ack timeout.
module opcode_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [11:0]       opcode,
  output logic              opcode_valid,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pc
);

  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be in 1..255");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        TMO_LOAD  = 8'(ACK_TIMEOUT);

  seq_state_e        state;
  logic [2:0]        hold_cnt;
  prog_word_t        word;
  logic [ADDR_W-1:0] pc_inc;
  logic              last;
  logic              tmr_load, tmr_en, tmr_expired;

  assign word   = unpack_word(prog_data);
  assign pc_inc = pc + 1'b1;
  assign last   = (pc == LAST_ADDR);

  assign tmr_load = (state == S_DECODE) && !word.halt;
  assign tmr_en   = (state == S_ISSUE);

  ack_timer u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TMO_LOAD),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      prog_addr    <= '0;
      opcode       <= '0;
      hold_cnt     <= '0;
      opcode_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc        <= '0;
            prog_addr <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        // prog_addr already equals pc; this cycle covers the ROM read latency.
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (word.halt) begin
            state <= S_DONE;
          end else begin
            opcode       <= word.opc;
            hold_cnt     <= word.hold;
            opcode_valid <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ack is checked first so it wins over a same-cycle expiry.
          if (ack) begin
            opcode_valid <= 1'b0;
            if (hold_cnt != 3'd0) begin
              state <= S_HOLD;
            end else if (last) begin
              state <= S_DONE;
            end else begin
              pc        <= pc_inc;
              prog_addr <= pc_inc;
              state     <= S_FETCH;
            end
          end else if (tmr_expired) begin
            opcode_valid <= 1'b0;
            error        <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt == 3'd1) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              pc        <= pc_inc;
              prog_addr <= pc_inc;
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed + randomized bench for opcode_sequencer: a transaction-level model
// predicts the issued opcode stream, handshake lengths, cycle count and status.
module tb_opcode_sequencer;
  import seq_pkg::*;

  localparam int AW    = 6;
  localparam int T     = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, ack;
  logic [AW-1:0] prog_addr, pc;
  logic [15:0]   prog_data;
  logic [11:0]   opcode;
  logic          opcode_valid, busy, done, error;

  logic [15:0] rom [DEPTH];
  int          dly [DEPTH];
  int          errors = 0;
  int          checks = 0;

  logic [11:0] exp_ops[$], obs_ops[$];
  int          exp_addr[$], obs_addr[$], exp_len[$], obs_len[$];
  int          exp_cyc, exp_pc;
  logic        exp_err;

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  opcode_sequencer #(.ADDR_W(AW), .ACK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .ack          (ack),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .pc           (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".prog_addr"}, 32'(prog_addr), 0);
    chk({tag, ".pc"}, 32'(pc), 0);
    chk({tag, ".opcode"}, 32'(opcode), 0);
    chk({tag, ".valid"}, 32'(opcode_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".error"}, 32'(error), 0);
  endtask

  task automatic fill_halt();
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = 16'h8000;
      dly[a] = 1;
    end
  endtask

  function automatic logic [15:0] rand_word(input int max_hold);
    logic [2:0] h;
    h = 3'($urandom_range(0, max_hold));
    return {1'b0, h, 12'($urandom)};
  endfunction

  // Walks the program as the sequencer should: per instruction FETCH+DECODE,
  // then min(delay, T) ISSUE cycles, then HOLD cycles; HALT/end/timeout add DONE.
  task automatic model();
    int         a, i;
    bit         fin;
    logic [15:0] w;
    exp_ops.delete(); exp_addr.delete(); exp_len.delete();
    a = 0; i = 0; fin = 0; exp_cyc = 0; exp_err = 1'b0;
    while (!fin) begin
      exp_cyc += 2;
      w = rom[a];
      if (w[15]) begin
        exp_cyc += 1; fin = 1;
      end else begin
        exp_ops.push_back(w[11:0]);
        exp_addr.push_back(a);
        if (dly[i] > T) begin
          exp_len.push_back(T);
          exp_cyc += T + 1; exp_err = 1'b1; fin = 1;
        end else begin
          exp_len.push_back(dly[i]);
          exp_cyc += dly[i] + int'(w[14:12]);
          i++;
          if (a == DEPTH - 1) begin
            exp_cyc += 1; fin = 1;
          end else begin
            a++;
          end
        end
      end
    end
    exp_pc = a;
  endtask

  // Starts the program and plays the control block: ack after dly[] valid
  // cycles, optional random start/ack noise whenever they must be ignored.
  task automatic run_prog(input string tag, input bit spur);
    int          n, k, done_n, busy_bad, opc_bad, n_cmp;
    logic        err1;
    logic [11:0] prev;
    bit          got;
    model();
    obs_ops.delete(); obs_addr.delete(); obs_len.delete();
    k = 0; got = 0; busy_bad = 0; opc_bad = 0; done_n = 0; err1 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    prev  = opcode;
    for (n = 1; n <= 3000 && !got; n++) begin
      @(negedge clk);
      if (n == 1) err1 = error;
      if (done) begin
        got = 1; done_n = n;
      end else begin
        if (!busy) busy_bad++;
        if (opcode !== prev && !(opcode_valid && k == 0)) opc_bad++;
        prev = opcode;
        if (opcode_valid) begin
          if (k == 0) begin
            obs_ops.push_back(opcode);
            obs_addr.push_back(int'(pc));
          end
          k++;
          ack = (k == dly[obs_ops.size() - 1]);
        end else begin
          if (k > 0) begin
            obs_len.push_back(k);
            k = 0;
          end
          ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    chk({tag, ".done_seen"}, 32'(got), 1);
    chk({tag, ".done_cycle"}, done_n, exp_cyc + 1);
    chk({tag, ".busy_gap"}, busy_bad, 0);
    chk({tag, ".opc_stable"}, opc_bad, 0);
    chk({tag, ".err_cleared"}, 32'(err1), 0);
    chk({tag, ".n_issued"}, obs_ops.size(), exp_ops.size());
    chk({tag, ".n_lens"}, obs_len.size(), exp_len.size());
    n_cmp = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < n_cmp; i++) begin
      chk($sformatf("%s.op%0d", tag, i), 32'(obs_ops[i]), 32'(exp_ops[i]));
      chk($sformatf("%s.addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      if (i < obs_len.size())
        chk($sformatf("%s.len%0d", tag, i), obs_len[i], exp_len[i]);
    end
    chk({tag, ".error"}, 32'(error), 32'(exp_err));
    chk({tag, ".pc"}, 32'(pc), exp_pc);
    chk({tag, ".busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".error_kept"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    int cnt;
    bit got;
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    fill_halt();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Linear program, ack on the second valid cycle.
    fill_halt();
    rom[0] = {8'h00, 4'h0, ALU_LD_A};
    rom[1] = {8'h00, 4'h0, ALU_LD_B};
    rom[2] = 16'h0C10;
    rom[3] = 16'h8000;
    dly[0] = 2; dly[1] = 2; dly[2] = 2;
    run_prog("linear", 1'b0);

    // Second instruction never acked: exactly T valid cycles, then error.
    fill_halt();
    rom[0] = 16'h0009; rom[1] = 16'h0C10; rom[2] = 16'h8000;
    dly[0] = 2; dly[1] = T + 3;
    run_prog("timeout", 1'b0);

    // HOLD=3, then an ack landing on the final timer cycle; start clears error.
    fill_halt();
    rom[0] = 16'h3009; rom[1] = 16'h100B; rom[2] = 16'h8000;
    dly[0] = 1; dly[1] = T;
    run_prog("hold", 1'b0);

    // No HALT anywhere: must stop after the last address without wrapping.
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = rand_word(2);
      dly[a] = $urandom_range(1, T);
    end
    run_prog("eop", 1'b1);

    // Reset while an opcode is being issued.
    fill_halt();
    for (int a = 0; a < 8; a++) begin
      rom[a] = {4'h0, 12'(a + 'h100)};
      dly[a] = 3;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (opcode_valid) got = 1;
    end
    chk("rst_mid.valid_seen", 32'(got), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || opcode_valid) cnt++;
    end
    chk("rst_mid.quiet", cnt, 0);

    // Random programs with HALT at a random point and occasional timeouts.
    for (int r = 0; r < 6; r++) begin
      int len;
      fill_halt();
      len = $urandom_range(1, 12);
      for (int a = 0; a < len; a++) begin
        rom[a] = rand_word(7);
        dly[a] = $urandom_range(1, T + 1);
      end
      run_prog($sformatf("rand%0d", r), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
